// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the CPU MEM stage and a word-only data memory.
// Handles byte/half extraction, sub-word read-modify-write and access fault detection.
module dmem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h10010000,
   parameter int unsigned DEPTH     = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        addr_err,
   output logic        mem_wena,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, LOAD, WR, RMW_RD, RMW_WR, RESP} state_t;

   state_t      state;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic        sign_q;
   logic [15:0] wdata_q;

   logic [31:0] word_idx;
   logic        acc_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   assign word_idx = (addr - BASE_ADDR) >> 2;

   // Word index 0 is write-protected by the memory, so a store there is rejected up front.
   assign acc_err = (size == 2'b11)
                  | ((size == 2'b01) & addr[0])
                  | ((size == 2'b10) & (addr[1:0] != 2'b00))
                  | (addr < BASE_ADDR)
                  | (word_idx >= DEPTH)
                  | (we & (word_idx == 32'd0));

   assign mem_wena = (state == WR) || (state == RMW_WR);

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (lane_q)
         2'd0: byte_sel = mem_rdata[7:0];
         2'd1: byte_sel = mem_rdata[15:8];
         2'd2: byte_sel = mem_rdata[23:16];
         2'd3: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (size_q)
         2'b00:   load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_val = {{16{sign_q & half_sel[15]}}, half_sel};
         default: load_val = mem_rdata;
      endcase

      merge_val = mem_rdata;
      if (size_q == 2'b00) begin
         case (lane_q)
            2'd0: merge_val[7:0]   = wdata_q[7:0];
            2'd1: merge_val[15:8]  = wdata_q[7:0];
            2'd2: merge_val[23:16] = wdata_q[7:0];
            2'd3: merge_val[31:24] = wdata_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merge_val[31:16] = wdata_q;
      end else begin
         merge_val[15:0] = wdata_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         addr_err  <= 1'b0;
         rdata     <= 32'd0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         size_q    <= 2'b00;
         lane_q    <= 2'b00;
         sign_q    <= 1'b0;
         wdata_q   <= 16'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  busy     <= 1'b1;
                  size_q   <= size;
                  lane_q   <= addr[1:0];
                  sign_q   <= sign_ext;
                  wdata_q  <= wdata[15:0];
                  mem_addr <= word_idx;
                  addr_err <= 1'b0;
                  if (acc_err) begin
                     state    <= RESP;
                     addr_err <= 1'b1;
                     done     <= 1'b1;
                     rdata    <= 32'd0;
                  end else if (!we) begin
                     state <= LOAD;
                  end else if (size == 2'b10) begin
                     state     <= WR;
                     mem_wdata <= wdata;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            LOAD: begin
               rdata <= load_val;
               done  <= 1'b1;
               state <= RESP;
            end
            WR: begin
               rdata <= 32'd0;
               done  <= 1'b1;
               state <= RESP;
            end
            RMW_RD: begin
               mem_wdata <= merge_val;
               state     <= RMW_WR;
            end
            RMW_WR: begin
               rdata <= 32'd0;
               done  <= 1'b1;
               state <= RESP;
            end
            RESP: begin
               busy     <= 1'b0;
               addr_err <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word memory that drops writes to index 0.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        addr_err;
   logic        mem_wena;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:511];

   int checks = 0;
   int failures = 0;
   int lat;
   int wena_cnt;
   logic [31:0] wena_addr;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] seen [$];
   int          exp_idx [4] = '{4, 7, 6, 5};

   always #5 clk = ~clk;

   dmem_access_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .size      (size),
      .sign_ext  (sign_ext),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .busy      (busy),
      .done      (done),
      .addr_err  (addr_err),
      .mem_wena  (mem_wena),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   assign mem_rdata = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 32'd0;

   always @(posedge clk) begin
      if (mem_wena && mem_addr != 32'd0 && mem_addr < 32'd512)
         mem[mem_addr[8:0]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access: drive for a single accept edge, then watch up to 8 cycles for done.
   task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
      logic got;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      got = 1'b0; lat = 0; wena_cnt = 0; wena_addr = 32'hFFFF_FFFF;
      r_rdata = 32'hXXXX_XXXX; r_err = 1'bx;
      for (int i = 1; i <= 8 && !got; i++) begin
         @(negedge clk);
         if (mem_wena) begin
            wena_cnt++;
            wena_addr = mem_addr;
         end
         if (done) begin
            got = 1'b1; lat = i; r_rdata = rdata; r_err = addr_err;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL done_timeout observed=none expected=done within 8 cycles");
      end
   endtask

   task automatic err_case(input string tag, input logic w, input logic [1:0] sz,
                           input logic [31:0] a);
      access(w, sz, 1'b0, a, 32'h1234_5678);
      chk({tag, "_lat"}, lat, 1);
      chk({tag, "_err"}, {31'd0, r_err}, 1);
      chk({tag, "_wena"}, wena_cnt, 0);
      chk({tag, "_rdata"}, r_rdata, 0);
   endtask

   initial begin
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_wena", {31'd0, mem_wena}, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_rdata", rdata, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Word store then load
      access(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF);
      chk("sw_wena_cnt", wena_cnt, 1);
      chk("sw_wena_addr", wena_addr, 2);
      chk("sw_lat", lat, 2);
      chk("sw_rdata", r_rdata, 0);
      access(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'd0);
      chk("lw_lat", lat, 2);
      chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);
      chk("lw_err", {31'd0, r_err}, 0);

      // Byte RMW, lane 2
      access(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h1122_3344);
      access(1'b1, 2'b00, 1'b0, 32'h1001_000A, 32'hFFFF_FFA5);
      chk("sb_lat", lat, 3);
      chk("sb_wena_cnt", wena_cnt, 1);
      chk("sb_mem", mem[2], 32'h11A5_3344);
      access(1'b0, 2'b00, 1'b1, 32'h1001_000A, 32'd0);
      chk("lb", r_rdata, 32'hFFFF_FFA5);
      access(1'b0, 2'b00, 1'b0, 32'h1001_000A, 32'd0);
      chk("lbu", r_rdata, 32'h0000_00A5);
      access(1'b0, 2'b00, 1'b1, 32'h1001_000B, 32'd0);
      chk("lb_lane3", r_rdata, 32'h0000_0011);

      // Halfword, upper half
      access(1'b1, 2'b10, 1'b0, 32'h1001_000C, 32'd0);
      access(1'b1, 2'b01, 1'b0, 32'h1001_000E, 32'h0000_8001);
      chk("sh_lat", lat, 3);
      chk("sh_mem", mem[3], 32'h8001_0000);
      access(1'b0, 2'b01, 1'b1, 32'h1001_000E, 32'd0);
      chk("lh", r_rdata, 32'hFFFF_8001);
      access(1'b0, 2'b01, 1'b0, 32'h1001_000E, 32'd0);
      chk("lhu", r_rdata, 32'h0000_8001);

      // Last valid word index
      access(1'b1, 2'b10, 1'b0, 32'h1001_07FC, 32'h5A5A_0001);
      chk("top_sw_err", {31'd0, r_err}, 0);
      access(1'b0, 2'b10, 1'b0, 32'h1001_07FC, 32'd0);
      chk("top_lw", r_rdata, 32'h5A5A_0001);

      err_case("e_lw_mis", 1'b0, 2'b10, 32'h1001_0002);
      err_case("e_sh_mis", 1'b1, 2'b01, 32'h1001_0001);
      err_case("e_size11", 1'b0, 2'b11, 32'h1001_0010);
      err_case("e_below", 1'b0, 2'b10, 32'h0FFF_FFFC);
      err_case("e_idx512", 1'b0, 2'b10, 32'h1001_0800);
      err_case("e_sw_idx0", 1'b1, 2'b10, 32'h1001_0000);
      access(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'd0);
      chk("post_err_lw", r_rdata, 32'h11A5_3344);

      // Back-to-back with req held: only IDLE edges accept
      for (int k = 0; k < 4; k++)
         access(1'b1, 2'b10, 1'b0, 32'h1001_0010 + 32'(4 * k), 32'hA000_0004 + 32'(k));
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) seen.push_back(rdata);
         req = 1'b1; we = 1'b0; size = 2'b10;
         addr = 32'h1001_0010 + 32'(4 * (i % 4));
      end
      @(negedge clk);
      if (done) seen.push_back(rdata);
      req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen.push_back(rdata);
      end
      chk("b2b_count", seen.size(), 4);
      for (int k = 0; k < 4 && k < seen.size(); k++)
         chk($sformatf("b2b_data%0d", k), seen[k], 32'hA000_0000 + 32'(exp_idx[k]));

      // Reset in RMW_RD
      access(1'b1, 2'b10, 1'b0, 32'h1001_0020, 32'h5566_7788);
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h1001_0021; wdata = 32'h0000_00EE;
      @(posedge clk);
      #1 req = 1'b0;
      chk("rmw_busy", {31'd0, busy}, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_wena", {31'd0, mem_wena}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_maddr", mem_addr, 0);
      chk("mid_rst_mwdata", mem_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_done", {31'd0, done}, 0);
      end
      chk("post_rst_mem", mem[8], 32'h5566_7788);
      access(1'b0, 2'b10, 1'b0, 32'h1001_0020, 32'd0);
      chk("post_rst_lw_lat", lat, 2);
      chk("post_rst_lw", r_rdata, 32'h5566_7788);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
